// File: rtl/instr_fetch_if.sv
// instr_fetch_if: fetch <-> decode bus.
// The fetch stage (master) presents instructions; decode (slave) returns
// stall and the redirect requests (jump / branch / call / ret).
interface instr_fetch_if #(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned INSTR_W = 19
);
    logic                stall;
    logic [INSTR_W-1:0]  instr;
    logic                instr_valid;
    logic [ADDR_W-1:0]   instr_pc;
    logic                jump_en;
    logic [10:0]         jump_addr;
    logic                branch_taken;
    logic [7:0]          branch_addr;
    logic                call_en;
    logic [10:0]         call_addr;
    logic                ret_en;

    modport master (
        output instr, instr_valid, instr_pc,
        input  stall, jump_en, jump_addr, branch_taken, branch_addr,
               call_en, call_addr, ret_en
    );

    modport slave (
        input  instr, instr_valid, instr_pc,
        output stall, jump_en, jump_addr, branch_taken, branch_addr,
               call_en, call_addr, ret_en
    );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage feeding the instruction parser.
// Owns the PC, drives a 1-cycle synchronous instruction ROM, takes
// redirects from decode (ret > call > jump > branch) with a one-bubble
// penalty and keeps a return-address stack.
// Optional feature: define IF_HALT_EN to make opcode 4'b1111 halt fetch
// until reset; without it `halted` is tied low.
module instr_fetch #(
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned INSTR_W   = 19,
    parameter int unsigned RAS_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_if.master       dec,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                ras_ovf,
    output logic                ras_unf,
    output logic                halted
);

    localparam int unsigned      PTR_W    = $clog2(RAS_DEPTH) + 1;
    localparam int unsigned      IDX_W    = PTR_W - 1;
    localparam logic [PTR_W-1:0] RAS_FULL = PTR_W'(RAS_DEPTH);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_BUBBLE
`ifdef IF_HALT_EN
        , S_HALT
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
    logic                valid_q, valid_d;
    logic [ADDR_W-1:0]   ras_q [RAS_DEPTH];
    logic [ADDR_W-1:0]   ras_d [RAS_DEPTH];
    logic [PTR_W-1:0]    ras_ptr_q, ras_ptr_d;
    logic [PTR_W-1:0]    pop_ptr;
    logic                ras_ovf_q, ras_ovf_d;
    logic                ras_unf_q, ras_unf_d;

    logic                accept;
    logic                halt_hit;
    logic                redir_req;
    logic                redirect;
    logic [ADDR_W-1:0]   ret_pc;
    logic [ADDR_W-1:0]   target;

    // instr is a straight pass-through of the ROM data; instr_pc/valid are
    // registered alongside so they describe the word coming back this cycle.
    assign dec.instr       = imem_rdata;
    assign dec.instr_valid = valid_q;
    assign dec.instr_pc    = instr_pc_q;
    assign ras_ovf         = ras_ovf_q;
    assign ras_unf         = ras_unf_q;

    // An instruction is consumed when it is live and decode is not stalling.
    assign accept = (state_q == S_RUN) && valid_q && !dec.stall;

`ifdef IF_HALT_EN
    logic halted_q, halted_d;
    assign halted   = halted_q;
    assign halt_hit = accept && (imem_rdata[INSTR_W-1 -: 4] == 4'b1111);
`else
    assign halted   = 1'b0;
    assign halt_hit = 1'b0;
`endif

    // Redirect target selection and return-address stack update.
    always_comb begin
        ras_d     = ras_q;
        ras_ptr_d = ras_ptr_q;
        ras_ovf_d = ras_ovf_q;
        ras_unf_d = ras_unf_q;

        pop_ptr   = ras_ptr_q - 1'b1;
        ret_pc    = (ras_ptr_q == '0) ? '0 : ras_q[pop_ptr[IDX_W-1:0]];

        redir_req = dec.ret_en | dec.call_en | dec.jump_en | dec.branch_taken;
        redirect  = accept && !halt_hit && redir_req;

        if (dec.ret_en)
            target = ret_pc;
        else if (dec.call_en)
            target = ADDR_W'(dec.call_addr);
        else if (dec.jump_en)
            target = ADDR_W'(dec.jump_addr);
        else
            target = ADDR_W'(dec.branch_addr);

        if (redirect) begin
            if (dec.ret_en) begin
                // Underflow returns to 0 and leaves the pointer at empty.
                if (ras_ptr_q == '0)
                    ras_unf_d = 1'b1;
                else
                    ras_ptr_d = pop_ptr;
            end else if (dec.call_en) begin
                // Overflow drops the push but the call is still taken.
                if (ras_ptr_q == RAS_FULL) begin
                    ras_ovf_d = 1'b1;
                end else begin
                    ras_d[ras_ptr_q[IDX_W-1:0]] = instr_pc_q + 1'b1;
                    ras_ptr_d                   = ras_ptr_q + 1'b1;
                end
            end
        end
    end

    // Fetch sequencing: next PC / valid / state and the ROM address.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        imem_addr  = fetch_pc_q;
`ifdef IF_HALT_EN
        halted_d   = halted_q;
`endif

        case (state_q)
            S_BOOT: begin
                state_d    = S_RUN;
                valid_d    = 1'b1;
                instr_pc_d = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + 1'b1;
            end
            S_RUN: begin
                if (dec.stall) begin
                    // Re-read the word being held so the ROM output stays put.
                    imem_addr = instr_pc_q;
`ifdef IF_HALT_EN
                end else if (halt_hit) begin
                    state_d  = S_HALT;
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
`endif
                end else if (redirect) begin
                    // Target goes to the ROM now; the word already in flight
                    // is squashed by the bubble cycle that follows.
                    imem_addr  = target;
                    state_d    = S_BUBBLE;
                    valid_d    = 1'b0;
                    fetch_pc_d = target;
                end else begin
                    instr_pc_d = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 1'b1;
                end
            end
            S_BUBBLE: begin
                state_d    = S_RUN;
                valid_d    = 1'b1;
                instr_pc_d = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + 1'b1;
            end
            default: begin
                // Halted: address frozen, nothing presented until reset.
                valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_BOOT;
            fetch_pc_q <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            ras_q      <= '{default: '0};
            ras_ptr_q  <= '0;
            ras_ovf_q  <= 1'b0;
            ras_unf_q  <= 1'b0;
`ifdef IF_HALT_EN
            halted_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            ras_q      <= ras_d;
            ras_ptr_q  <= ras_ptr_d;
            ras_ovf_q  <= ras_ovf_d;
            ras_unf_q  <= ras_unf_d;
`ifdef IF_HALT_EN
            halted_q   <= halted_d;
`endif
        end
    end

endmodule
